tile_router_v1_00_a_output_arbiter: RTL

//   Packet-locked round-robin arbiter for one tile router output port.

---
 rtl/tile_router_v1_00_a_output_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/tile_router_v1_00_a_output_arbiter.sv
// ---------------------------------------------------------------------------
// tile_router_v1_00_a_output_arbiter
//
// Packet-locked (wormhole) round-robin arbiter for one tile router output
// port. Up to C_NUM_CLIENTS input ports compete for the port. Once a client
// is granted, the grant is held until that client's LAST flit has been
// transferred. Accepted flits pass through a one-entry registered buffer.
//
// Optional feature macro: TILE_ROUTER_ARB_WATCHDOG_EN
//   defined   : a stalled lock (granted client holding valid low) is released
//               after C_WDOG_CYCLES idle LOCKED cycles, pulsing wdog_err.
//   undefined : no watchdog; wdog_err tied low; the lock is held forever.
//
// Ports
//   clk              clock
//   rst              asynchronous active-low reset
//   clientX_valid    [N]     per-client flit valid
//   clientX_accept   [N]     per-client flit accept
//   clientX_payload  [N*W]   client i flit at [i*W +: W]; bit W-1 = LAST
//   output_valid             output flit valid
//   output_accept            downstream accept
//   output_payload   [W]     output flit
//   grant            [N]     one-hot current grant (status)
//   busy                     high while a packet lock is held
//   wdog_err                 one-cycle pulse on watchdog release
// ---------------------------------------------------------------------------
module tile_router_v1_00_a_output_arbiter #(
  parameter int C_NUM_CLIENTS  = 8,
  parameter int C_PACKET_WIDTH = 66,
  parameter int C_WDOG_CYCLES  = 64
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [C_NUM_CLIENTS-1:0]                clientX_valid,
  output logic [C_NUM_CLIENTS-1:0]                clientX_accept,
  input  logic [C_NUM_CLIENTS*C_PACKET_WIDTH-1:0] clientX_payload,
  output logic                                    output_valid,
  input  logic                                    output_accept,
  output logic [C_PACKET_WIDTH-1:0]               output_payload,
  output logic [C_NUM_CLIENTS-1:0]                grant,
  output logic                                    busy,
  output logic                                    wdog_err
);

  localparam int PTR_W = (C_NUM_CLIENTS > 1) ? $clog2(C_NUM_CLIENTS) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam logic [SUM_W-1:0] N_SUM    = SUM_W'(C_NUM_CLIENTS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(C_NUM_CLIENTS - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                    state_reg, state_next;
  logic [C_NUM_CLIENTS-1:0]  grant_reg, grant_next;
  logic [PTR_W-1:0]          g_idx_reg, g_idx_next;
  logic [PTR_W-1:0]          rr_ptr_reg, rr_ptr_next;
  logic                      out_valid_reg;
  logic [C_PACKET_WIDTH-1:0] out_payload_reg;

  logic                      load_ok;
  logic                      sel_valid;
  logic [C_PACKET_WIDTH-1:0] sel_payload;
  logic                      xfer;
  logic                      wdog_fire;
  logic [PTR_W-1:0]          ptr_after_g;

  logic                      req_found;
  logic [PTR_W-1:0]          pick_idx;
  logic [SUM_W-1:0]          cand_sum;

  logic [C_PACKET_WIDTH-1:0] payload_arr [C_NUM_CLIENTS];

  // The buffer can take a new flit when empty or when it drains this cycle.
  assign load_ok = !out_valid_reg || output_accept;

  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_CLIENTS; gi++) begin : g_client
      assign payload_arr[gi]    = clientX_payload[gi*C_PACKET_WIDTH +: C_PACKET_WIDTH];
      assign clientX_accept[gi] = (state_reg == ST_LOCKED) &&
                                  (g_idx_reg == PTR_W'(gi)) && load_ok;
    end
  endgenerate

  assign sel_valid   = clientX_valid[g_idx_reg];
  assign sel_payload = payload_arr[g_idx_reg];
  assign xfer        = (state_reg == ST_LOCKED) && sel_valid && load_ok;
  assign ptr_after_g = (g_idx_reg == PTR_LAST) ? '0 : (g_idx_reg + PTR_ONE);

  // Round-robin search starting at rr_ptr. The index is formed one bit wider
  // and wrapped by explicit compare so non-power-of-2 client counts work.
  always_comb begin
    req_found = 1'b0;
    pick_idx  = '0;
    cand_sum  = '0;
    for (int k = 0; k < C_NUM_CLIENTS; k++) begin
      cand_sum = {1'b0, rr_ptr_reg} + SUM_W'(k);
      if (cand_sum >= N_SUM) begin
        cand_sum = cand_sum - N_SUM;
      end
      if (!req_found && clientX_valid[cand_sum[PTR_W-1:0]]) begin
        req_found = 1'b1;
        pick_idx  = cand_sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    g_idx_next  = g_idx_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_found) begin
          state_next = ST_LOCKED;
          grant_next = {{(C_NUM_CLIENTS-1){1'b0}}, 1'b1} << pick_idx;
          g_idx_next = pick_idx;
        end else begin
          grant_next = '0;
        end
      end
      ST_LOCKED: begin
        // Release on the LAST flit, or when the watchdog gives up on a
        // stalled client; either way the next search starts after g.
        if ((xfer && sel_payload[C_PACKET_WIDTH-1]) || wdog_fire) begin
          state_next  = ST_IDLE;
          grant_next  = '0;
          rr_ptr_next = ptr_after_g;
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      grant_reg  <= '0;
      g_idx_reg  <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      g_idx_reg  <= g_idx_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // One-entry output buffer. A load in the same cycle the downstream takes
  // the current flit simply overwrites it, so streaming has no bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg   <= 1'b0;
      out_payload_reg <= '0;
    end else if (xfer) begin
      out_valid_reg   <= 1'b1;
      out_payload_reg <= sel_payload;
    end else if (output_accept) begin
      out_valid_reg   <= 1'b0;
    end
  end

`ifdef TILE_ROUTER_ARB_WATCHDOG_EN
  localparam int WCNT_W = $clog2(C_WDOG_CYCLES + 1);

  logic [WCNT_W-1:0] wdog_cnt_reg, wdog_cnt_next;
  logic              wdog_stall;
  logic              wdog_err_reg;

  // Counts consecutive LOCKED cycles in which the granted client has no
  // valid flit. Cleared while idle (so each new lock starts from zero) and
  // on every granted transfer.
  always_comb begin
    wdog_stall    = (state_reg == ST_LOCKED) && !sel_valid;
    wdog_fire     = wdog_stall && (wdog_cnt_reg == WCNT_W'(C_WDOG_CYCLES - 1));
    wdog_cnt_next = wdog_cnt_reg;
    if ((state_reg != ST_LOCKED) || xfer || wdog_fire) begin
      wdog_cnt_next = '0;
    end else if (wdog_stall) begin
      wdog_cnt_next = wdog_cnt_reg + WCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_reg <= '0;
      wdog_err_reg <= 1'b0;
    end else begin
      wdog_cnt_reg <= wdog_cnt_next;
      wdog_err_reg <= wdog_fire;
    end
  end

  assign wdog_err = wdog_err_reg;
`else
  localparam int unused_wdog_cycles = C_WDOG_CYCLES;

  assign wdog_fire = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  assign output_valid   = out_valid_reg;
  assign output_payload = out_payload_reg;
  assign grant          = grant_reg;
  assign busy           = (state_reg == ST_LOCKED);

endmodule
